// File: rtl/demux_2_for_4_bits_buffered_pkg.sv
// demux_pkg: shared defaults and channel-select type for the buffered
// 2-way 4-bit demultiplexer and its per-channel FIFOs.
package demux_pkg;

  // Default data width, FIFO depth and transfer-counter width.
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 8;

  // Output channel selector.
  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_sel_t;

endpackage : demux_pkg

// File: rtl/demux_2_for_4_bits_buffered_fifo.sv
// fifo_2_for_4_bits: synchronous FIFO with registered storage, wrapping
// pointers and an occupancy count. The head output reads 0 when empty so
// downstream never sees stale data. Push while full and pop while empty
// are ignored.
module fifo_2_for_4_bits
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_do_push;
  logic             w_do_pop;

  // Advance a pointer, wrapping from the last entry back to entry 0.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage, pointers and occupancy; reset discards every buffered entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : fifo_2_for_4_bits

// File: rtl/demux_2_for_4_bits_buffered.sv
// demux_2_for_4_bits_buffered: routes one valid/ready input stream to one
// of two independently buffered output channels chosen by in_select.
// Optional feature macro: DEMUX_2_FOR_4_BITS_STATS_EN adds saturating
// per-channel pop counters (out0_count / out1_count).
module demux_2_for_4_bits_buffered
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count,
`endif
  input  logic             out1_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  chan_sel_t       w_sel;
  logic            w_full0;
  logic            w_full1;
  logic            w_empty0;
  logic            w_empty1;
  logic            w_accept;
  logic            w_push0;
  logic            w_push1;
  logic            w_pop0;
  logic            w_pop1;
  logic [CW-1:0]   w_count0;
  logic [CW-1:0]   w_count1;
  logic            w_unused;

  assign w_sel = chan_sel_t'(in_select);

  // Ready reflects only the selected channel's registered fullness.
  always_comb begin
    in_ready = 1'b0;
    case (w_sel)
      CH0:     in_ready = !w_full0;
      CH1:     in_ready = !w_full1;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept   = in_valid && in_ready;
  assign w_push0    = w_accept && (w_sel == CH0);
  assign w_push1    = w_accept && (w_sel == CH1);
  assign out0_valid = !w_empty0;
  assign out1_valid = !w_empty1;
  assign w_pop0     = out0_valid && out0_ready;
  assign w_pop1     = out1_valid && out1_ready;

  // Occupancy is not needed here; kept on the FIFO for observability.
  assign w_unused = ^{w_count0, w_count1};

  fifo_2_for_4_bits #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push0),
    .i_push_data (in_data),
    .i_pop       (w_pop0),
    .o_full      (w_full0),
    .o_empty     (w_empty0),
    .o_head      (out0_data),
    .o_count     (w_count0)
  );

  fifo_2_for_4_bits #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push1),
    .i_push_data (in_data),
    .i_pop       (w_pop1),
    .o_full      (w_full1),
    .o_empty     (w_empty1),
    .o_head      (out1_data),
    .o_count     (w_count1)
  );

`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Per-channel pop counters that stick at their maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= {CNT_W{1'b0}};
      r_cnt1 <= {CNT_W{1'b0}};
    end else begin
      if (w_pop0 && (r_cnt0 != {CNT_W{1'b1}})) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_pop1 && (r_cnt1 != {CNT_W{1'b1}})) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  assign out0_count = r_cnt0;
  assign out1_count = r_cnt1;
`endif

endmodule : demux_2_for_4_bits_buffered

// File: tb/tb_demux_2_for_4_bits_buffered.sv
// Self-checking bench for demux_2_for_4_bits_buffered: queue-based channel
// model, per-cycle compare process, directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_demux_2_for_4_bits_buffered;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_select = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready = 1'b1;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready = 1'b1;
`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
  logic [CNT_W-1:0] out0_count;
  logic [CNT_W-1:0] out1_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit model_on = 1'b0;

  // Model: per-channel queues of pending beats and pop tallies.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  int pops0 = 0;
  int pops1 = 0;

  demux_2_for_4_bits_buffered #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
    , .CNT_W (CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
    .out0_count (out0_count),
    .out1_count (out1_count),
`endif
    .out1_ready (out1_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the pre-edge queue state.
  always @(posedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      pops0 = 0;
      pops1 = 0;
    end else begin
      bit do_push;
      do_push = in_valid && ((in_select ? q1.size() : q0.size()) < DEPTH);
      if (q0.size() > 0 && out0_ready) begin
        void'(q0.pop_front());
        pops0++;
      end
      if (q1.size() > 0 && out1_ready) begin
        void'(q1.pop_front());
        pops1++;
      end
      if (do_push) begin
        if (in_select) q1.push_back(in_data);
        else           q0.push_back(in_data);
      end
    end
  end

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    if (model_on) begin
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
      chk("out0_data", 32'(out0_data), (q0.size() > 0) ? 32'(q0[0]) : 32'd0);
      chk("out1_data", 32'(out1_data), (q1.size() > 0) ? 32'(q1[0]) : 32'd0);
      chk("in_ready", 32'(in_ready),
          32'(((in_select ? q1.size() : q0.size()) < DEPTH)));
`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
      chk("out0_count", 32'(out0_count), 32'((pops0 > CMAX) ? CMAX : pops0));
      chk("out1_count", 32'(out1_count), 32'((pops1 > CMAX) ? CMAX : pops1));
`endif
    end
  end

  // Advance to just after the next falling edge (safe drive/sample point).
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] d);
    in_valid  = v;
    in_select = s;
    in_data   = d;
  endtask

  initial begin
    // Reset.
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0);
    cyc();
    cyc();
    reset = 1'b0;
    model_on = 1'b1;
    cyc();
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_d0", 32'(out0_data), 32'd0);
    in_select = 1'b0; #1;
    chk("rst_rdy_s0", 32'(in_ready), 32'd1);
    in_select = 1'b1; #1;
    chk("rst_rdy_s1", 32'(in_ready), 32'd1);
`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
    chk("rst_cnt0", 32'(out0_count), 32'd0);
    chk("rst_cnt1", 32'(out1_count), 32'd0);
`endif

    // Route A to channel 0, 5 to channel 1.
    drive(1'b1, 1'b0, 4'hA);
    cyc();
    chk("t2_v0", 32'(out0_valid), 32'd1);
    chk("t2_d0", 32'(out0_data), 32'hA);
    drive(1'b1, 1'b1, 4'h5);
    cyc();
    chk("t2_v1", 32'(out1_valid), 32'd1);
    chk("t2_d1", 32'(out1_data), 32'h5);
    chk("t2_v0_drained", 32'(out0_valid), 32'd0);
    drive(1'b0, 1'b0, 4'h0);
    cyc();
`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
    chk("t2_cnt0", 32'(out0_count), 32'd1);
    chk("t2_cnt1", 32'(out1_count), 32'd1);
`endif

    // Fill channel 0; channel 1 stays open.
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 4'h1);
    cyc();
    drive(1'b1, 1'b0, 4'h2);
    cyc();
    drive(1'b1, 1'b0, 4'h3); #1;
    chk("t3_full_rdy", 32'(in_ready), 32'd0);
    in_select = 1'b1; #1;
    chk("t3_other_rdy", 32'(in_ready), 32'd1);
    cyc();
    drive(1'b0, 1'b0, 4'h0);
    chk("t3_d1", 32'(out1_data), 32'h3);
    chk("t3_head0", 32'(out0_data), 32'h1);
    out0_ready = 1'b1;
    cyc();
    chk("t3_second0", 32'(out0_data), 32'h2);
    cyc();
    chk("t3_empty0", 32'(out0_valid), 32'd0);

    // Simultaneous push and pop on channel 1.
    out1_ready = 1'b0;
    drive(1'b1, 1'b1, 4'h7);
    cyc();
    chk("t4_d7", 32'(out1_data), 32'h7);
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 4'h8); #1;
    chk("t4_rdy", 32'(in_ready), 32'd1);
    cyc();
    drive(1'b0, 1'b0, 4'h0);
    chk("t4_v8", 32'(out1_valid), 32'd1);
    chk("t4_d8", 32'(out1_data), 32'h8);
    cyc();
    chk("t4_drained", 32'(out1_valid), 32'd0);

    // Reset while both channels are full and a beat is offered.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b1, 1'b0, 4'h1); cyc();
    drive(1'b1, 1'b0, 4'h2); cyc();
    drive(1'b1, 1'b1, 4'h3); cyc();
    drive(1'b1, 1'b1, 4'h4); cyc();
    chk("t5_pre_v0", 32'(out0_valid), 32'd1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'hE);
    cyc();
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0);
    chk("t5_v0", 32'(out0_valid), 32'd0);
    chk("t5_v1", 32'(out1_valid), 32'd0);
    chk("t5_d0", 32'(out0_data), 32'd0);
    drive(1'b1, 1'b0, 4'hF);
    cyc();
    drive(1'b0, 1'b0, 4'h0);
    chk("t5_dF", 32'(out0_data), 32'hF);
    out0_ready = 1'b1;
    cyc();
    chk("t5_alone", 32'(out0_valid), 32'd0);
    out1_ready = 1'b1;

`ifdef DEMUX_2_FOR_4_BITS_STATS_EN
    // Counter saturation on channel 0.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(1'b1, 1'b0, 4'h9);
    cyc();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) drive(1'b0, 1'b0, 4'h0);
      cyc();
      chk("t6_sat", 32'(out0_count), 32'((k > 3) ? 3 : k));
    end
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      in_valid   = $urandom_range(0, 1);
      in_select  = $urandom_range(0, 1);
      in_data    = 4'($urandom);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_demux_2_for_4_bits_buffered
